gen_clk_en_sampler: RTL and testbench



---
 rtl/gen_clk_en_sampler.sv | 162 ++++++++++++++++
 tb/tb_gen_clk_en_sampler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen_clk_en_sampler.sv
// gen_clk_en_sampler
//   Lock-qualified clock-enable divider and data sampler for the PLL output
//   clock domain. Waits for LOCK_WAIT consecutive locked cycles, then produces
//   a one-cycle strobe every N_eff cycles (N_eff = max(div_ratio,1)) and
//   captures data at full rate and at the divided rate. Everything runs on clk.
//
//   Optional feature macro: GEN_CLK_SAMPLE_CNT_EN
//     defined   -> 16-bit saturating count of divided-rate captures
//     undefined -> sample_cnt_o tied to 16'h0000, no counter logic
//
//   Ports:
//     clk          in   PLL output clock, sole clock
//     rst_n        in   asynchronous active-low reset
//     pll_lock     in   lock indicator, already synchronous to clk
//     enable       in   capture enable
//     div_ratio    in   divide ratio N (0 and 1 both mean divide-by-1)
//     data_i       in   data to sample
//     ready_o      out  high while in RUN
//     div_stb_o    out  one-cycle strobe per divided period
//     data_o       out  full-rate captured data
//     data_div_o   out  divided-rate captured data
//     sample_cnt_o out  number of divided-rate captures (saturating)
module gen_clk_en_sampler #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int LOCK_WAIT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  div_ratio,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  div_stb_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DATA_WIDTH-1:0] data_div_o,
    output logic [15:0]           sample_cnt_o
);

    localparam int SETTLE_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [DIV_WIDTH-1:0]  n_eff;
    logic [DIV_WIDTH-1:0]  n_req;
    logic                  in_run;
    logic                  stb;

    // Divide-by-0 is treated as divide-by-1 so the period is never empty.
    assign n_req  = (div_ratio == '0) ? DIV_WIDTH'(1) : div_ratio;
    assign in_run = (state == RUN);
    // Decoded purely from registers so the strobe is glitch-free.
    assign stb    = in_run && (cnt == (n_eff - DIV_WIDTH'(1)));

    assign ready_o   = in_run;
    assign div_stb_o = stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pll_lock) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!pll_lock) begin
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_W'(LOCK_WAIT - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!pll_lock) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts locked cycles spent in SETTLE; zero everywhere else so that each
    // SETTLE entry starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if ((state == SETTLE) && (state_next == SETTLE)) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Divider: the ratio is latched only on RUN entry and at a wrap, so a
    // div_ratio change never shortens or stretches the period in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            n_eff <= DIV_WIDTH'(1);
        end else if (in_run && (state_next == RUN)) begin
            if (stb) begin
                cnt   <= '0;
                n_eff <= n_req;
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
        end else if (state_next == RUN) begin
            cnt   <= '0;
            n_eff <= n_req;
        end else begin
            cnt <= '0;
        end
    end

    // Capture is qualified by the registered state, so a strobe in the last
    // RUN cycle still captures even though lock has just been lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o     <= '0;
            data_div_o <= '0;
        end else if (in_run && enable) begin
            data_o <= data_i;
            if (stb) begin
                data_div_o <= data_i;
            end
        end
    end

`ifdef GEN_CLK_SAMPLE_CNT_EN
    logic [15:0] sample_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (in_run && enable && stb && (sample_cnt != 16'hFFFF)) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

    assign sample_cnt_o = sample_cnt;
`else
    assign sample_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_gen_clk_en_sampler.sv
// Testbench for gen_clk_en_sampler: directed scenarios followed by random
// stimulus, all checked against a cycle-level behavioural reference model.
module tb_gen_clk_en_sampler;

    localparam int DW = 8;
    localparam int VW = 8;
    localparam int LW = 16;

    logic          clk;
    logic          rst_n;
    logic          pll_lock;
    logic          enable;
    logic [VW-1:0] div_ratio;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          div_stb_o;
    logic [DW-1:0] data_o;
    logic [DW-1:0] data_div_o;
    logic [15:0]   sample_cnt_o;

    int n_tests;
    int n_fail;

    // Reference model: RUN is simply "at least LW+1 consecutive locked edges";
    // the period is tracked as cycles remaining until the strobe.
    int          m_streak;
    bit          m_run;
    int          m_left;
    logic [7:0]  m_data;
    logic [7:0]  m_div;
    int          m_cnt;

    gen_clk_en_sampler #(
        .DATA_WIDTH(DW),
        .DIV_WIDTH (VW),
        .LOCK_WAIT (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .enable      (enable),
        .div_ratio   (div_ratio),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .div_stb_o   (div_stb_o),
        .data_o      (data_o),
        .data_div_o  (data_div_o),
        .sample_cnt_o(sample_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int neff(input logic [7:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_reset();
        m_streak = 0;
        m_run    = 1'b0;
        m_left   = 0;
        m_data   = '0;
        m_div    = '0;
        m_cnt    = 0;
    endtask

    task automatic model_edge(input logic lk, input logic en, input logic [7:0] dv,
                              input logic [7:0] d);
        bit stb_now;
        bit run_next;
        stb_now = m_run && (m_left == 1);
        if (m_run && en) begin
            m_data = d;
            if (stb_now) begin
                m_div = d;
`ifdef GEN_CLK_SAMPLE_CNT_EN
                if (m_cnt < 16'hFFFF) m_cnt++;
`endif
            end
        end
        m_streak = lk ? ((m_streak < 100000) ? m_streak + 1 : m_streak) : 0;
        run_next = (m_streak >= LW + 1);
        if (!run_next)        m_left = 0;
        else if (!m_run)      m_left = neff(dv);
        else if (stb_now)     m_left = neff(dv);
        else                  m_left = m_left - 1;
        m_run = run_next;
    endtask

    task automatic check_all();
        chk("ready", ready_o, m_run);
        chk("stb", div_stb_o, m_run && (m_left == 1));
        chk("data", data_o, m_data);
        chk("data_div", data_div_o, m_div);
        chk("sample_cnt", sample_cnt_o, m_cnt);
    endtask

    task automatic step(input logic lk, input logic en, input logic [7:0] dv,
                        input logic [7:0] d);
        pll_lock  = lk;
        enable    = en;
        div_ratio = dv;
        data_i    = d;
        @(posedge clk);
        model_edge(lk, en, dv, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        pll_lock  = 1'b0;
        enable    = 1'b0;
        div_ratio = '0;
        data_i    = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts locked edges until ready_o rises; returns the edge count.
    task automatic lock_until_ready(input logic [7:0] dv, output int k);
        k = 0;
        do begin
            step(1'b1, 1'b0, dv, 8'h00);
            k++;
        end while ((ready_o !== 1'b1) && (k < 100));
    endtask

    initial begin
        int k;
        logic lk;
        logic en;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        model_reset();

        // Reset, then lock from cycle 5.
        do_reset();
        repeat (4) step(1'b0, 1'b1, 8'd4, 8'hA5);
        lock_until_ready(8'd4, k);
        chk("lock_latency", k, LW + 1);

        // Divide-by-4 with incrementing data.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'd4, 8'(i));
        chk("data_div_after_12", data_div_o, 8'd11);
`ifdef GEN_CLK_SAMPLE_CNT_EN
        chk("cnt_after_12", sample_cnt_o, 16'd3);
`else
        chk("cnt_after_12", sample_cnt_o, 16'd0);
`endif

        // Divide-by-0 and divide-by-1.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'd0, 8'(8'h40 + i));
        chk("div0_equal", data_div_o, data_o);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'd1, 8'(8'h60 + i));
            chk("div1_stb", div_stb_o, 1'b1);
        end

        // Ratio change 4 -> 2 mid-period.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd4, 8'(8'h80 + i));
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 8'd4, 8'(8'h90 + i));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'd2, 8'(8'hA0 + i));

        // Lock drop in RUN, then relock with divide-by-3.
        step(1'b0, 1'b0, 8'd3, 8'hEE);
        chk("ready_drop", ready_o, 1'b0);
        lock_until_ready(8'd3, k);
        chk("relock_latency", k, LW + 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 8'd3, 8'(8'hB0 + i));

        // enable low: strobes continue, captures hold.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'd3, 8'($urandom));

        // Lock lost on a strobe edge with enable high.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd1, 8'(8'hC0 + i));
        step(1'b0, 1'b1, 8'd1, 8'hC7);
        chk("stb_edge_capture", data_div_o, 8'hC7);

        // Lock drop in SETTLE at count 10.
        do_reset();
        repeat (11) step(1'b1, 1'b0, 8'd2, 8'h00);
        step(1'b0, 1'b0, 8'd2, 8'h00);
        lock_until_ready(8'd2, k);
        chk("settle_restart", k, LW + 1);

        // Asynchronous reset pulse mid-RUN.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'd2, 8'(8'hD0 + i));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_ready", ready_o, 1'b0);
        chk("async_data", data_o, 8'h00);
        chk("async_data_div", data_div_o, 8'h00);
        chk("async_cnt", sample_cnt_o, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            lk = ($urandom_range(0, 63) != 0);
            en = lk ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            step(lk, en, 8'($urandom_range(0, 5)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
